// File: rtl/word_aligner_pkg.sv
// Shared types and constants for the word aligner: FSM state encoding,
// default sync/header patterns, offset width and saturating increment helpers.
package word_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    localparam logic [31:0] SYNC_WORD_DEFAULT   = 32'hACCCCCCC;
    localparam logic [31:0] HEADER_MASK_DEFAULT = 32'hF0000000;
    localparam int          OFFSET_W            = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/word_aligner_if.sv
// Byte-in / word-out bundle of the word aligner. The statistics outputs exist
// only when WORD_ALIGNER_STATS_EN is defined.
interface word_aligner_if;
    import word_align_pkg::*;

    logic [7:0]          data_in;
    logic                data_in_valid;
    logic                realign;
    logic [31:0]         word_out;
    logic                word_valid;
    logic                locked;
    logic [OFFSET_W-1:0] align_offset;
    logic [1:0]          state_out;
`ifdef WORD_ALIGNER_STATS_EN
    logic [15:0]         header_err_count;
    logic [7:0]          lock_loss_count;
`endif

    // Byte source / word sink side
    modport master (
        output data_in, data_in_valid, realign,
        input  word_out, word_valid, locked, align_offset, state_out
`ifdef WORD_ALIGNER_STATS_EN
        , input header_err_count, lock_loss_count
`endif
    );

    // Aligner side
    modport slave (
        input  data_in, data_in_valid, realign,
        output word_out, word_valid, locked, align_offset, state_out
`ifdef WORD_ALIGNER_STATS_EN
        , output header_err_count, lock_loss_count
`endif
    );

endinterface

// File: rtl/sync_match8.sv
// Compares all eight 32-bit candidates of a 40-bit window against a pattern
// and reports the match vector plus the lowest matching offset.
module sync_match8 (
    input  logic [39:0] window_i,
    input  logic [31:0] pattern_i,
    output logic [7:0]  match_o,
    output logic [2:0]  first_o,
    output logic        any_o
);

    // Candidate k starts k bits after the oldest window bit
    always_comb begin
        match_o = '0;
        for (int k = 0; k < 8; k++) begin
            match_o[k] = (window_i[39-k -: 32] == pattern_i);
        end
    end

    // Lowest-index priority encoder: scan downward so the smallest k wins
    always_comb begin
        first_o = '0;
        for (int k = 7; k >= 0; k--) begin
            if (match_o[k]) first_o = k[2:0];
        end
    end

    assign any_o = |match_o;

endmodule

// File: rtl/word_aligner.sv
// Recovers 32-bit word boundaries from a deserialized byte stream: searches
// all 8 bit offsets for SYNC_WORD, confirms over LOCK_COUNT sync words, then
// emits one aligned word every 4 valid bytes and drops lock after
// UNLOCK_COUNT consecutive header failures.
// Optional: define WORD_ALIGNER_STATS_EN for header-error / lock-loss counters.
module word_aligner
    import word_align_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter logic [31:0] HEADER_MASK  = HEADER_MASK_DEFAULT,
    parameter int          LOCK_COUNT   = 4,
    parameter int          UNLOCK_COUNT = 8
) (
    input  logic           clk160,
    input  logic           rst,
    word_aligner_if.slave  bus
);

    localparam logic [7:0]  LOCK_THR   = 8'(LOCK_COUNT);
    localparam logic [7:0]  UNLOCK_THR = 8'(UNLOCK_COUNT);
    localparam logic [31:0] HDR_REF    = SYNC_WORD & HEADER_MASK;

    // The oldest byte of the 40-bit window is never looked at before it is
    // shifted out, so only the newest 32 bits are stored; the full window is
    // the stored bits plus the incoming byte.
    logic [31:0]         window_q, window_d;
    logic [39:0]         win_shift;
    align_state_e        state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          lock_phase_q, lock_phase_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [7:0]          match_cnt_q, match_cnt_d;
    logic [7:0]          fail_cnt_q, fail_cnt_d;
    logic [31:0]         word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic                locked_q;
`ifdef WORD_ALIGNER_STATS_EN
    logic [15:0]         hdr_err_q, hdr_err_d;
    logic [7:0]          loss_q, loss_d;
`endif

    logic [7:0]          match_vec;
    logic [2:0]          first_k;
    logic                any_match;
    logic [5:0]          cand_top;
    logic [31:0]         cand;
    logic                phase_hit;
    logic                sync_hit;
    logic                header_ok;
    logic [7:0]          match_inc;
    logic [7:0]          fail_inc;

    assign win_shift = {window_q, bus.data_in};

    sync_match8 u_match (
        .window_i  (win_shift),
        .pattern_i (SYNC_WORD),
        .match_o   (match_vec),
        .first_o   (first_k),
        .any_o     (any_match)
    );

    assign cand_top  = 6'd39 - {3'd0, off_q};
    assign cand      = win_shift[cand_top -: 32];
    assign sync_hit  = match_vec[off_q];
    assign header_ok = ((cand & HEADER_MASK) == HDR_REF);
    assign phase_hit = (phase_q == lock_phase_q);
    assign match_inc = sat_inc8(match_cnt_q);
    assign fail_inc  = sat_inc8(fail_cnt_q);

    // Next-state logic: realign overrides everything, otherwise only a valid byte moves state
    always_comb begin
        window_d     = window_q;
        state_d      = state_q;
        phase_d      = phase_q;
        lock_phase_d = lock_phase_q;
        off_d        = off_q;
        match_cnt_d  = match_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
`ifdef WORD_ALIGNER_STATS_EN
        hdr_err_d    = hdr_err_q;
        loss_d       = loss_q;
`endif
        if (bus.realign) begin
            if (bus.data_in_valid) window_d = win_shift[31:0];
            state_d     = SEARCH;
            phase_d     = 2'd0;
            match_cnt_d = 8'd0;
            fail_cnt_d  = 8'd0;
`ifdef WORD_ALIGNER_STATS_EN
            if (state_q == LOCKED) loss_d = sat_inc8(loss_q);
`endif
        end else if (bus.data_in_valid) begin
            window_d = win_shift[31:0];
            phase_d  = phase_q + 2'd1;
            unique case (state_q)
                SEARCH: begin
                    if (any_match) begin
                        off_d        = first_k;
                        lock_phase_d = phase_q;
                        match_cnt_d  = 8'd1;
                        if (LOCK_THR <= 8'd1) begin
                            state_d    = LOCKED;
                            fail_cnt_d = 8'd0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (phase_hit) begin
                        if (sync_hit) begin
                            match_cnt_d = match_inc;
                            if (match_inc >= LOCK_THR) begin
                                state_d    = LOCKED;
                                fail_cnt_d = 8'd0;
                            end
                        end else begin
                            state_d     = SEARCH;
                            match_cnt_d = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (phase_hit) begin
                        word_d       = cand;
                        word_valid_d = 1'b1;
                        if (header_ok) begin
                            fail_cnt_d = 8'd0;
                        end else begin
                            fail_cnt_d = fail_inc;
`ifdef WORD_ALIGNER_STATS_EN
                            hdr_err_d = sat_inc16(hdr_err_q);
`endif
                            if (fail_inc >= UNLOCK_THR) begin
                                state_d = SEARCH;
`ifdef WORD_ALIGNER_STATS_EN
                                loss_d = sat_inc8(loss_q);
`endif
                            end
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State and output registers; locked is registered alongside the state
    always_ff @(posedge clk160) begin
        if (rst) begin
            window_q     <= '0;
            state_q      <= SEARCH;
            phase_q      <= '0;
            lock_phase_q <= '0;
            off_q        <= '0;
            match_cnt_q  <= '0;
            fail_cnt_q   <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
`ifdef WORD_ALIGNER_STATS_EN
            hdr_err_q    <= '0;
            loss_q       <= '0;
`endif
        end else begin
            window_q     <= window_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            lock_phase_q <= lock_phase_d;
            off_q        <= off_d;
            match_cnt_q  <= match_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            locked_q     <= (state_d == LOCKED);
`ifdef WORD_ALIGNER_STATS_EN
            hdr_err_q    <= hdr_err_d;
            loss_q       <= loss_d;
`endif
        end
    end

    assign bus.word_out     = word_q;
    assign bus.word_valid   = word_valid_q;
    assign bus.locked       = locked_q;
    assign bus.align_offset = off_q;
    assign bus.state_out    = state_q;
`ifdef WORD_ALIGNER_STATS_EN
    assign bus.header_err_count = hdr_err_q;
    assign bus.lock_loss_count  = loss_q;
`endif

endmodule

// File: tb/tb_word_aligner.sv
// Scoreboard bench for word_aligner. The reference model works on a plain
// bit history (earliest bit first) and derives candidates from it directly.
// Statistics checks are active when WORD_ALIGNER_STATS_EN is defined.
module tb_word_aligner;
    import word_align_pkg::*;

    localparam logic [31:0] SYNC = 32'hACCCCCCC;
    localparam logic [31:0] MASK = 32'hF0000000;
    localparam int          LC   = 4;
    localparam int          UC   = 8;

    logic clk160 = 1'b0;
    logic rst;
    always #5 clk160 = ~clk160;

    word_aligner_if bus();

    word_aligner #(
        .SYNC_WORD    (SYNC),
        .HEADER_MASK  (MASK),
        .LOCK_COUNT   (LC),
        .UNLOCK_COUNT (UC)
    ) dut (
        .clk160 (clk160),
        .rst    (rst),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        wv;
        logic [31:0] w;
        logic [2:0]  off;
        logic [15:0] he;
        logic [7:0]  ll;
    } stat_t;

    stat_t       exp_q[$];
    logic [31:0] wexp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 0;

    // ---------------- reference model ----------------
    bit          m_win[$];
    int          m_state, m_off, m_lphase, m_phase, m_match, m_fail, m_he, m_ll;
    logic [31:0] m_word;
    bit          m_wv;

    function automatic logic [31:0] m_cand(int k);
        logic [31:0] c = '0;
        for (int i = 0; i < 32; i++) c = {c[30:0], m_win[k+i]};
        return c;
    endfunction

    task automatic m_reset();
        m_win.delete();
        repeat (40) m_win.push_back(1'b0);
        m_state = 0; m_off = 0; m_lphase = 0; m_phase = 0;
        m_match = 0; m_fail = 0; m_he = 0; m_ll = 0;
        m_word = '0; m_wv = 0;
    endtask

    task automatic m_shift(logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_win.push_back(b[i]);
        while (m_win.size() > 40) void'(m_win.pop_front());
    endtask

    task automatic m_step(bit r, bit v, logic [7:0] b, bit ra);
        int old_phase, found;
        logic [31:0] c;
        if (r) begin m_reset(); return; end
        m_wv = 0;
        if (ra) begin
            if (v) m_shift(b);
            if (m_state == 2 && m_ll < 255) m_ll++;
            m_state = 0; m_match = 0; m_fail = 0; m_phase = 0;
            return;
        end
        if (!v) return;
        m_shift(b);
        old_phase = m_phase;
        m_phase = (m_phase + 1) % 4;
        case (m_state)
            0: begin
                found = -1;
                for (int k = 0; k < 8; k++)
                    if (found < 0 && m_cand(k) == SYNC) found = k;
                if (found >= 0) begin
                    m_off = found; m_lphase = old_phase; m_match = 1;
                    if (LC <= 1) begin m_state = 2; m_fail = 0; end
                    else m_state = 1;
                end
            end
            1: if (old_phase == m_lphase) begin
                if (m_cand(m_off) == SYNC) begin
                    if (m_match < 255) m_match++;
                    if (m_match >= LC) begin m_state = 2; m_fail = 0; end
                end else begin
                    m_state = 0; m_match = 0;
                end
            end
            default: if (old_phase == m_lphase) begin
                c = m_cand(m_off);
                m_word = c; m_wv = 1;
                wexp_q.push_back(c);
                if ((c & MASK) == (SYNC & MASK)) m_fail = 0;
                else begin
                    if (m_fail < 255) m_fail++;
                    if (m_he < 65535) m_he++;
                    if (m_fail >= UC) begin
                        m_state = 0;
                        if (m_ll < 255) m_ll++;
                    end
                end
            end
        endcase
    endtask

    function automatic stat_t m_snap();
        stat_t s;
        s.st = 2'(m_state); s.lk = (m_state == 2); s.wv = m_wv; s.w = m_word;
        s.off = 3'(m_off);
`ifdef WORD_ALIGNER_STATS_EN
        s.he = 16'(m_he); s.ll = 8'(m_ll);
`else
        s.he = '0; s.ll = '0;
`endif
        return s;
    endfunction

    // ---------------- stimulus ----------------
    bit s_bits[$];
    bit tog = 0;

    task automatic cyc(bit r, bit v, logic [7:0] b, bit ra);
        rst = r; bus.data_in = b; bus.data_in_valid = v; bus.realign = ra;
        m_step(r, v, b, ra);
        @(posedge clk160);
        exp_q.push_back(m_snap());
        #1;
    endtask

    task automatic add_word(logic [31:0] w);
        for (int i = 31; i >= 0; i--) s_bits.push_back(w[i]);
    endtask

    // vmode: 0 = always valid, 1 = strict 50% toggle, 2 = random
    task automatic drain(int vmode);
        logic [7:0] b;
        bit v;
        logic [31:0] r;
        while (s_bits.size() >= 8) begin
            if (vmode == 0) v = 1;
            else if (vmode == 1) begin tog = ~tog; v = tog; end
            else v = ($urandom_range(0, 1) == 1);
            if (v) begin
                for (int i = 0; i < 8; i++) b = {b[6:0], s_bits.pop_front()};
                cyc(0, 1, b, 0);
            end else begin
                r = $urandom();
                cyc(0, 0, r[7:0], 0);
            end
        end
    endtask

    task automatic send(logic [31:0] w, int n, int vmode);
        repeat (n) add_word(w);
        drain(vmode);
    endtask

    task automatic send_bad(int n, int vmode);
        logic [31:0] r;
        repeat (n) begin
            r = $urandom();
            add_word({4'h0, r[27:0]});
        end
        drain(vmode);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    stat_t       act_s, exp_s;
    logic [31:0] wexp;
    int          cyc_n = 0, gap_last = -1, gap_exp = 0;

    always @(negedge clk160) begin
        cyc_n++;
        if (mon_on && exp_q.size() > 0) begin
            exp_s = exp_q.pop_front();
            act_s.st = bus.state_out; act_s.lk = bus.locked; act_s.wv = bus.word_valid;
            act_s.w = bus.word_out; act_s.off = bus.align_offset;
`ifdef WORD_ALIGNER_STATS_EN
            act_s.he = bus.header_err_count; act_s.ll = bus.lock_loss_count;
`else
            act_s.he = '0; act_s.ll = '0;
`endif
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL status @%0d: got st=%0d lk=%0b wv=%0b w=%h off=%0d he=%0d ll=%0d expected st=%0d lk=%0b wv=%0b w=%h off=%0d he=%0d ll=%0d",
                         cyc_n, act_s.st, act_s.lk, act_s.wv, act_s.w, act_s.off, act_s.he, act_s.ll,
                         exp_s.st, exp_s.lk, exp_s.wv, exp_s.w, exp_s.off, exp_s.he, exp_s.ll);
            end
            if (bus.word_valid === 1'b1) begin
                checks++;
                if (wexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word: got %h with no word expected", bus.word_out);
                end else begin
                    wexp = wexp_q.pop_front();
                    if (bus.word_out !== wexp) begin
                        errors++;
                        $display("FAIL word: got %h expected %h", bus.word_out, wexp);
                    end
                end
                if (gap_exp != 0 && gap_last >= 0) begin
                    checks++;
                    if (cyc_n - gap_last != gap_exp) begin
                        errors++;
                        $display("FAIL spacing: got %0d cycles expected %0d", cyc_n - gap_last, gap_exp);
                    end
                end
                gap_last = cyc_n;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        rst = 1; bus.data_in = '0; bus.data_in_valid = 0; bus.realign = 0;
        m_reset();
        mon_on = 1;
        repeat (3) cyc(1, 0, 8'h00, 0);
        chk("reset_state", {30'd0, bus.state_out}, 32'd0);
        chk("reset_locked", {31'd0, bus.locked}, 32'd0);
        chk("reset_word", bus.word_out, 32'd0);

        // 5-bit skew ahead of the word stream
        repeat (5) s_bits.push_back(1'($urandom_range(0, 1)));

        // continuous sync, valid high
        gap_exp = 4; gap_last = -1;
        send(SYNC, 8, 0);
        chk("lock_A", {31'd0, bus.locked}, 32'd1);
        chk("offset_A", {29'd0, bus.align_offset}, 32'd5);

        // header failures: 7 bad, 1 good, 8 bad
        send_bad(7, 0);
        send(SYNC, 1, 0);
        chk("hold_after_7bad", {31'd0, bus.locked}, 32'd1);
        send_bad(8, 0);
        send(SYNC, 1, 0);
        chk("drop_after_8bad", {31'd0, bus.locked}, 32'd0);
        gap_exp = 0;
        send(SYNC, 7, 0);
        chk("relock_B", {31'd0, bus.locked}, 32'd1);

        // 50% valid while locked
        send(SYNC, 1, 1);
        gap_exp = 8; gap_last = -1;
        for (int i = 0; i < 12; i++) begin
            r = $urandom();
            send((i % 3 == 0) ? SYNC : {4'hA, r[27:0]}, 1, 1);
        end
        gap_exp = 0;
        chk("lock_C", {31'd0, bus.locked}, 32'd1);

        // realign while locked
        cyc(0, 0, 8'h00, 1);
        chk("realign_state", {30'd0, bus.state_out}, 32'd0);
        chk("realign_locked", {31'd0, bus.locked}, 32'd0);
        chk("realign_wv", {31'd0, bus.word_valid}, 32'd0);
        send(SYNC, 8, 0);
        chk("relock_D", {31'd0, bus.locked}, 32'd1);

        // corrupted sync during verification
        cyc(0, 0, 8'h00, 1);
        send(SYNC, 2, 0);
        send(SYNC ^ 32'h0001_0000, 1, 0);
        send(SYNC, 8, 0);
        chk("relock_E", {31'd0, bus.locked}, 32'd1);

        // random mixture
        for (int i = 0; i < 60; i++) begin
            r = $urandom();
            case ($urandom_range(0, 5))
                0, 1: send(SYNC, 1, 2);
                2:    send({4'hA, r[27:0]}, 1, 2);
                3:    send({4'h3, r[27:0]}, 1, 2);
                4:    send(r, 1, 2);
                default: begin
                    if ($urandom_range(0, 3) == 0) cyc(0, 0, 8'h00, 1);
                    else send(SYNC, 1, 0);
                end
            endcase
        end

        // statistics: 10 header errors across 2 lock losses
        repeat (2) cyc(1, 0, 8'h00, 0);
        send(SYNC, 8, 0);
        send_bad(8, 0);
        send(SYNC, 8, 0);
        send_bad(2, 0);
        send(SYNC, 2, 0);
        cyc(0, 0, 8'h00, 1);
`ifdef WORD_ALIGNER_STATS_EN
        chk("stats_hdr_err", {16'd0, bus.header_err_count}, 32'd10);
        chk("stats_loss", {24'd0, bus.lock_loss_count}, 32'd2);
`endif
        repeat (2) cyc(1, 0, 8'h00, 0);
`ifdef WORD_ALIGNER_STATS_EN
        chk("stats_hdr_rst", {16'd0, bus.header_err_count}, 32'd0);
        chk("stats_loss_rst", {24'd0, bus.lock_loss_count}, 32'd0);
`endif
        chk("final_state", {30'd0, bus.state_out}, 32'd0);

        repeat (3) cyc(0, 0, 8'h00, 0);
        @(negedge clk160);
        chk("words_left", wexp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
